// File: rtl/dcm_pll_rst_ctrl_pkg.sv
// Shared definitions for the dcm_pll reset sequencer: FSM state codes and default timing.
package dcm_pll_rst_ctrl_pkg;

   localparam logic [1:0] PLL_RST   = 2'd0;
   localparam logic [1:0] WAIT_LOCK = 2'd1;
   localparam logic [1:0] STABLE    = 2'd2;
   localparam logic [1:0] RUN       = 2'd3;

   localparam int unsigned DEF_RST_CYCLES    = 4;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 4096;
   localparam int unsigned DEF_STABLE_CYCLES = 256;
   localparam int unsigned DEF_USE_LOCKED    = 1;
   localparam int unsigned DEF_CNT_W         = 13;
   localparam int unsigned DEF_RETRY_W       = 4;

endpackage

// File: rtl/dcm_pll_rst_ctrl_sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module dcm_pll_rst_ctrl_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/dcm_pll_rst_ctrl.sv
// Power-up / recovery reset sequencer for the dcm_pll clock generator.
// Pulses the PLL reset, waits for a stable lock, then releases the controller reset.
module dcm_pll_rst_ctrl
   import dcm_pll_rst_ctrl_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned USE_LOCKED    = DEF_USE_LOCKED,
   parameter int unsigned CNT_W         = DEF_CNT_W,
   parameter int unsigned RETRY_W       = DEF_RETRY_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               restart,
   input  logic               clr_status,
   output logic               pll_rst,
   output logic               ctrl_rst,
   output logic               ready,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [1:0]         state
);

   localparam bit LOCK_EN = (USE_LOCKED != 0);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

   logic               lock_sync;
   logic               lock_s;
   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               pll_rst_q, ctrl_rst_q, ready_q;
   logic               lock_lost_q, lock_lost_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               lost_set;
   logic               retry_inc;

   dcm_pll_rst_ctrl_sync2 u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_sync)
   );

   // Without a lock port the lock is implied by the timeout alone.
   assign lock_s = LOCK_EN ? lock_sync : 1'b0;

   always_comb begin
      state_d   = state_q;
      lost_set  = 1'b0;
      retry_inc = 1'b0;
      if (restart) begin
         state_d = PLL_RST;
      end else begin
         case (state_q)
            PLL_RST: begin
               if (count_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (LOCK_EN && lock_s) begin
                  state_d = STABLE;
               end else if (count_q == TIMEOUT_LAST) begin
                  if (LOCK_EN) begin
                     state_d   = PLL_RST;
                     retry_inc = 1'b1;
                  end else begin
                     state_d = STABLE;
                  end
               end
            end
            STABLE: begin
               if (LOCK_EN && !lock_s) begin
                  state_d  = PLL_RST;
                  lost_set = 1'b1;
               end else if (count_q == STABLE_LAST) begin
                  state_d = RUN;
               end
            end
            default: begin
               if (LOCK_EN && !lock_s) begin
                  state_d  = PLL_RST;
                  lost_set = 1'b1;
               end
            end
         endcase
      end

      // RUN has no terminal count, so the counter parks there instead of wrapping.
      if (restart || (state_d != state_q)) begin
         count_d = '0;
      end else if (state_q == RUN) begin
         count_d = count_q;
      end else begin
         count_d = count_q + CNT_W'(1);
      end

      if (lost_set) begin
         lock_lost_d = 1'b1;
      end else if (clr_status) begin
         lock_lost_d = 1'b0;
      end else begin
         lock_lost_d = lock_lost_q;
      end

      if (retry_inc) begin
         retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
      end else if (clr_status) begin
         retry_d = '0;
      end else begin
         retry_d = retry_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= PLL_RST;
         count_q     <= '0;
         pll_rst_q   <= 1'b1;
         ctrl_rst_q  <= 1'b1;
         ready_q     <= 1'b0;
         lock_lost_q <= 1'b0;
         retry_q     <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         pll_rst_q   <= (state_d == PLL_RST);
         ctrl_rst_q  <= (state_d != RUN);
         ready_q     <= (state_d == RUN);
         lock_lost_q <= lock_lost_d;
         retry_q     <= retry_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign ctrl_rst  = ctrl_rst_q;
   assign ready     = ready_q;
   assign lock_lost = lock_lost_q;
   assign retry_cnt = retry_q;
   assign state     = state_q;

endmodule

// File: tb/tb_dcm_pll_rst_ctrl.sv
// Self-checking bench for dcm_pll_rst_ctrl: default-timing directed sequences, a no-lock-port
// instance, and a short-timing instance driven by a vector table and random stimulus vs a model.
module tb_dcm_pll_rst_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Default-timing instance
   logic       rst = 1'b1, pll_locked = 1'b0, restart = 1'b0, clr_status = 1'b0;
   logic       pll_rst, ctrl_rst, ready, lock_lost;
   logic [3:0] retry_cnt;
   logic [1:0] state;

   dcm_pll_rst_ctrl u_dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .restart    (restart),
      .clr_status (clr_status),
      .pll_rst    (pll_rst),
      .ctrl_rst   (ctrl_rst),
      .ready      (ready),
      .lock_lost  (lock_lost),
      .retry_cnt  (retry_cnt),
      .state      (state)
   );

   // Instance without a lock port in use
   logic       n_rst = 1'b1;
   logic       n_pll_rst, n_ctrl_rst, n_ready, n_lock_lost;
   logic [3:0] n_retry_cnt;
   logic [1:0] n_state;

   dcm_pll_rst_ctrl #(.USE_LOCKED(0)) u_nolock (
      .clk        (clk),
      .rst        (n_rst),
      .pll_locked (1'b0),
      .restart    (1'b0),
      .clr_status (1'b0),
      .pll_rst    (n_pll_rst),
      .ctrl_rst   (n_ctrl_rst),
      .ready      (n_ready),
      .lock_lost  (n_lock_lost),
      .retry_cnt  (n_retry_cnt),
      .state      (n_state)
   );

   // Short-timing instance
   localparam int F_RST = 4, F_TMO = 16, F_STB = 8;
   logic       f_rst = 1'b1, f_locked = 1'b0, f_restart = 1'b0, f_clr = 1'b0;
   logic       f_pll_rst, f_ctrl_rst, f_ready, f_lock_lost;
   logic [3:0] f_retry_cnt;
   logic [1:0] f_state;

   dcm_pll_rst_ctrl #(
      .RST_CYCLES    (F_RST),
      .LOCK_TIMEOUT  (F_TMO),
      .STABLE_CYCLES (F_STB)
   ) u_fast (
      .clk        (clk),
      .rst        (f_rst),
      .pll_locked (f_locked),
      .restart    (f_restart),
      .clr_status (f_clr),
      .pll_rst    (f_pll_rst),
      .ctrl_rst   (f_ctrl_rst),
      .ready      (f_ready),
      .lock_lost  (f_lock_lost),
      .retry_cnt  (f_retry_cnt),
      .state      (f_state)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // sel: 0 pll_rst low, 1 pll_rst high, 2 ready high, 3 state STABLE
   task automatic wait_for(input string name, input int sel, input int bound, output int n);
      bit hit;
      hit = 1'b0;
      n   = 0;
      while (!hit && n < bound) begin
         tick(1);
         n++;
         case (sel)
            0:       hit = (pll_rst == 1'b0);
            1:       hit = (pll_rst == 1'b1);
            2:       hit = (ready == 1'b1);
            3:       hit = (state == 2'd2);
            default: hit = 1'b1;
         endcase
      end
      if (!hit) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: timeout after %0d cycles", name, bound);
      end
   endtask

   // Reference model for u_fast: phase index plus time spent in that phase.
   int m_ph, m_el, m_retry;
   bit m_s1, m_s2, m_ll;

   function automatic int m_len(input int ph);
      case (ph)
         0:       return F_RST;
         1:       return F_TMO;
         2:       return F_STB;
         default: return 1 << 30;
      endcase
   endfunction

   task automatic model_reset();
      m_ph = 0; m_el = 0; m_retry = 0;
      m_s1 = 0; m_s2 = 0; m_ll = 0;
   endtask

   task automatic model_step(input bit rs, input bit cl, input bit lk);
      bit ls, lost, tmo;
      int nph;
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      lost = 0;
      tmo  = 0;
      nph  = m_ph;
      if (rs) nph = 0;
      else if (m_ph >= 2 && !ls) begin
         nph  = 0;
         lost = 1;
      end else if (m_ph == 1 && ls) nph = 2;
      else if (m_el + 1 == m_len(m_ph)) begin
         if (m_ph == 1) begin
            nph = 0;
            tmo = 1;
         end else nph = m_ph + 1;
      end
      if (rs || nph != m_ph) m_el = 0;
      else m_el++;
      m_ph = nph;
      if (lost) m_ll = 1;
      else if (cl) m_ll = 0;
      if (tmo) m_retry = (m_retry == 15) ? 15 : m_retry + 1;
      else if (cl) m_retry = 0;
   endtask

   function automatic logic [9:0] model_out();
      logic [1:0] st;
      logic [3:0] rc;
      st = 2'(m_ph);
      rc = 4'(m_retry);
      return {st, m_ph == 0, m_ph != 3, m_ph == 3, m_ll, rc};
   endfunction

   function automatic logic [9:0] fast_out();
      return {f_state, f_pll_rst, f_ctrl_rst, f_ready, f_lock_lost, f_retry_cnt};
   endfunction

   typedef struct {
      bit         restart;
      bit         clr;
      bit         locked;
      int         n;
      logic [1:0] st;
      bit         prst;
      bit         crst;
      bit         rdy;
      bit         ll;
      logic [3:0] retry;
   } vec_t;

   vec_t tbl[15];

   initial begin
      int n, n2;
      logic [9:0] exp_v;

      tbl[0]  = '{0, 0, 0,  2, 2'd0, 1, 1, 0, 0, 4'd0};
      tbl[1]  = '{0, 0, 0,  2, 2'd1, 0, 1, 0, 0, 4'd0};
      tbl[2]  = '{0, 0, 0, 16, 2'd0, 1, 1, 0, 0, 4'd1};
      tbl[3]  = '{0, 0, 0,  4, 2'd1, 0, 1, 0, 0, 4'd1};
      tbl[4]  = '{0, 0, 1,  3, 2'd2, 0, 1, 0, 0, 4'd1};
      tbl[5]  = '{0, 0, 1,  8, 2'd3, 0, 0, 1, 0, 4'd1};
      tbl[6]  = '{0, 0, 0,  3, 2'd0, 1, 1, 0, 1, 4'd1};
      tbl[7]  = '{0, 1, 1,  1, 2'd0, 1, 1, 0, 0, 4'd0};
      tbl[8]  = '{0, 0, 1,  3, 2'd1, 0, 1, 0, 0, 4'd0};
      tbl[9]  = '{0, 0, 1,  1, 2'd2, 0, 1, 0, 0, 4'd0};
      tbl[10] = '{1, 0, 1,  1, 2'd0, 1, 1, 0, 0, 4'd0};
      tbl[11] = '{0, 0, 1,  4, 2'd1, 0, 1, 0, 0, 4'd0};
      tbl[12] = '{0, 0, 1,  1, 2'd2, 0, 1, 0, 0, 4'd0};
      tbl[13] = '{0, 0, 1,  8, 2'd3, 0, 0, 1, 0, 4'd0};
      tbl[14] = '{1, 0, 1,  1, 2'd0, 1, 1, 0, 0, 4'd0};

      // Reset values while rst held
      tick(2);
      check("rst_vals", {state, pll_rst, ctrl_rst, ready, lock_lost, retry_cnt},
            {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0});

      // Lock arrives 20 cycles after pll_rst falls
      rst = 1'b0;
      wait_for("t1_pll_rst_fall", 0, 20, n);
      check("t1_pll_rst_width", n, 4);
      tick(20);
      pll_locked = 1'b1;
      wait_for("t1_ready", 2, 400, n);
      check_range("t1_ready_latency", n, 256 + 2, 256 + 3);
      check("t1_run_outs", {state, pll_rst, ctrl_rst, retry_cnt, lock_lost},
            {2'd3, 1'b0, 1'b0, 4'd0, 1'b0});

      // No lock: retry period and count
      pll_locked = 1'b0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      wait_for("t2_fall1", 0, 20, n);
      wait_for("t2_rise1", 1, 5000, n2);
      check("t2_first_retry_time", n + n2, 4 + 4096);
      check("t2_retry_1", retry_cnt, 1);
      wait_for("t2_fall2", 0, 20, n);
      wait_for("t2_rise2", 1, 5000, n2);
      check("t2_retry_period", n + n2, 4 + 4096);
      check("t2_retry_2", retry_cnt, 2);

      pll_locked = 1'b1;
      wait_for("t2_recover", 2, 400, n);
      check("t2_retry_kept", {retry_cnt, lock_lost}, {4'd2, 1'b0});

      // One-cycle lock glitch in RUN
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(2);
      check("t3_drop_outs", {ctrl_rst, ready, pll_rst, lock_lost}, 4'b1011);
      wait_for("t3_recover", 2, 400, n);
      check("t3_lost_sticky", {lock_lost, ctrl_rst}, 2'b10);

      // Restart in RUN and in STABLE
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      check("t4_restart_run", {state, lock_lost, retry_cnt}, {2'd0, 1'b1, 4'd2});
      wait_for("t4_to_stable", 3, 50, n);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      check("t4_restart_stable", {state, lock_lost, retry_cnt}, {2'd0, 1'b1, 4'd2});

      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      check("t4_clr_status", {lock_lost, retry_cnt}, {1'b0, 4'd0});

      // clr_status coincides with the lock-drop edge: set wins
      wait_for("t6_to_run", 2, 400, n);
      pll_locked = 1'b0;
      tick(2);
      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
      check("t6_clr_vs_drop", {lock_lost, state}, {1'b1, 2'd0});

      // Async reset between edges, mid WAIT_LOCK
      tick(10);
      check("t6_in_wait", state, 2'd1);
      #3 rst = 1'b1;
      #1;
      check("t6_async_rst", {state, pll_rst, ctrl_rst, ready, lock_lost, retry_cnt},
            {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0});
      tick(1);
      rst = 1'b0;

      // No lock port: ready after the full timeout plus settle
      n_rst = 1'b0;
      n = 0;
      while (!n_ready && n < 5000) begin
         tick(1);
         n++;
      end
      check("t5_nolock_ready_time", n, 4 + 4096 + 256);
      check("t5_nolock_outs", {n_ctrl_rst, n_retry_cnt, n_lock_lost}, {1'b0, 4'd0, 1'b0});

      // Vector table on the short-timing instance
      f_rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         f_restart = tbl[i].restart;
         f_clr     = tbl[i].clr;
         f_locked  = tbl[i].locked;
         tick(tbl[i].n);
         exp_v = {tbl[i].st, tbl[i].prst, tbl[i].crst, tbl[i].rdy, tbl[i].ll, tbl[i].retry};
         check($sformatf("tbl[%0d]", i), fast_out(), exp_v);
      end

      // Random stimulus against the model
      f_restart = 1'b0;
      f_clr     = 1'b0;
      f_locked  = 1'b0;
      f_rst     = 1'b1;
      tick(2);
      f_rst = 1'b0;
      model_reset();
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 29) == 0) f_locked = ~f_locked;
         f_restart = ($urandom_range(0, 149) == 0);
         f_clr     = ($urandom_range(0, 59) == 0);
         tick(1);
         model_step(f_restart, f_clr, f_locked);
         check($sformatf("rand[%0d]", i), fast_out(), model_out());
      end

      // Long lock absence saturates the retry counter
      f_restart = 1'b0;
      f_clr     = 1'b0;
      f_locked  = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick(1);
         model_step(1'b0, 1'b0, 1'b0);
         check($sformatf("sat[%0d]", i), fast_out(), model_out());
      end
      check("sat_retry_15", f_retry_cnt, 4'd15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
